rv32_alu: RTL and testbench
===========================

Name: rv32_alu

Overview:
- Single-cycle RV32I integer ALU with registered output, sitting in the execute stage.
- Selects one of 13 operations via one-hot enable strobes.
- Second operand is the register value or the immediate, chosen by imm_sel.
- Also produces PC-relative results: link address for JAL/JALR, PC+imm for AUIPC, and imm for LUI.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- pc_in  input  32  PC of the current instruction
- src1_data  input  32  rs1 value, signed
- src2_data  input  32  rs2 value, signed
- imm_val  input  32  sign-extended immediate
- imm_sel  input  1  1 = operand B is imm_val; 0 = operand B is src2_data
- add_en, sub_en, and_en, or_en, xor_en, sll_en, srl_en, sra_en, slt_en  input  1 each  ALU operation strobes
- jalr_en, jal_en, auipc_en, lui_en  input  1 each  control-flow/upper-immediate strobes
- result_out  output  32  registered result, signed

Behaviour:
- Operands: A = src1_data; B = imm_sel ? imm_val : src2_data.
- add: A+B. sub: A−B. Both are modulo 2^32; overflow is ignored.
- and/or/xor: bitwise A op B.
- sll: A << B[4:0]. srl: logical right shift by B[4:0]. sra: arithmetic right shift by B[4:0]. B[31:5] is ignored.
- slt: 32'd1 if signed A < signed B, else 32'd0.
- jal, jalr: pc_in + 4, the link address. Target computation is outside this block.
- auipc: pc_in + imm_val, independent of imm_sel.
- lui: imm_val, independent of imm_sel.
- No enable asserted: next result is 32'd0.
- Multiple enables asserted: fixed priority, highest first: lui, auipc, jal, jalr, add, sub, and, or, xor, sll, srl, sra, slt (then sltu if present). No error flag.
- Timing: the combinational result is captured on the rising clk edge. result_out is valid one cycle after inputs are applied and holds until the next edge. Throughput is one operation per cycle.
- Reset: when rst_n=0 at a rising edge, result_out becomes 32'h0 regardless of enables. Reset mid-operation discards the in-flight result. The first valid result appears on the edge after rst_n deasserts.
- Boundaries:
  - pc_in=32'hFFFFFFFC with jal gives 32'h0 (wraps).
  - sra of 32'h80000000 by 31 gives 32'hFFFFFFFF.
  - slt(0x80000000, 0x7FFFFFFF) gives 1.

Optional Feature:
- Macro: ALU_SLTU_EN.
- Defined:
  - Adds input port sltu_en (1 bit), placed after slt_en.
  - Result is 32'd1 if unsigned A < unsigned B, else 0.
  - Lowest priority.
- Undefined:
  - No sltu_en port.
  - Behaviour is otherwise identical.

Decomposition:
- alu_pkg holds:
  - XLEN = 32
  - SHAMT_W = 5
  - PC_STEP = 32'd4
  - Localparam indices for the one-hot op vector (OP_ADD…OP_LUI, OP_SLTU).
  - An alu_op_t packed one-hot typedef.
- rv32_alu packs the strobes into alu_op_t, muxes operand B, and registers the result.
- One sub-module, alu_shifter: combinational; inputs A, shamt[4:0], and mode {sll, srl, sra}; output 32 bits.

Test Plan:
- Reset: rst_n=0 with add_en=1, src1=5, src2=7. result_out stays 0. After rst_n=1, the next edge gives 32'h0000000C.
- Arithmetic/imm_sel:
  - add, src1=0x10, src2=0x20, imm_sel=0 → 0x30.
  - Same with imm_val=0xFFFFFFFF, imm_sel=1 → 0x0000000F.
  - sub, src1=0, src2=1 → 0xFFFFFFFF.
- Logic/shift, src1=0xF0F0F0F0, B=0x0F0F00FF:
  - and → 0x000000F0; or → 0xFFFFF0FF; xor → 0xFFFFF00F.
  - src1=0x80000000 with B=0x00000024 (shamt 4): sll → 0, srl → 0x08000000, sra → 0xF8000000.
- Compare: slt with (−1, 1) → 1; (1, −1) → 0; equal operands → 0. With ALU_SLTU_EN, sltu(−1, 1) → 0.
- PC ops, pc_in=0x00001000, imm_val=0x12345000:
  - jal → 0x1004; jalr → 0x1004.
  - auipc → 0x12346000; lui → 0x12345000.
  - pc_in=0xFFFFFFFC with jal → 0.
- Priority/idle:
  - All enables 0 → 0.
  - lui_en and add_en both 1 → imm_val.
  - Back-to-back ops on consecutive cycles each appear exactly one cycle later.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and the one-hot operation vector for rv32_alu.
// Bit OP_SLTU exists always; it is only driven when ALU_SLTU_EN is defined.
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_JALR  = 9;
  localparam int OP_JAL   = 10;
  localparam int OP_AUIPC = 11;
  localparam int OP_LUI   = 12;
  localparam int OP_SLTU  = 13;
  localparam int OP_W     = 14;

  typedef logic [OP_W-1:0] alu_op_t;

endpackage

// File: rtl/alu_shifter.sv
// Combinational barrel shifter for sll/srl/sra.
// Mode is one-hot {sll, srl, sra}; all-zero mode yields zero.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    a_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic [2:0]         mode_i,
  output logic [XLEN-1:0]    y_o
);

  // pick the shift flavour; sll wins if several are set
  always_comb begin
    y_o = '0;
    priority case (1'b1)
      mode_i[2]: y_o = a_i << shamt_i;
      mode_i[1]: y_o = a_i >> shamt_i;
      mode_i[0]: y_o = $unsigned($signed(a_i) >>> shamt_i);
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/rv32_alu.sv
// RV32I execute-stage ALU with a registered result.
// Optional macro ALU_SLTU_EN adds the sltu_en strobe (lowest priority).
module rv32_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] src1_data,
  input  logic [XLEN-1:0] src2_data,
  input  logic [XLEN-1:0] imm_val,
  input  logic            imm_sel,
  input  logic            add_en,
  input  logic            sub_en,
  input  logic            and_en,
  input  logic            or_en,
  input  logic            xor_en,
  input  logic            sll_en,
  input  logic            srl_en,
  input  logic            sra_en,
  input  logic            slt_en,
`ifdef ALU_SLTU_EN
  input  logic            sltu_en,
`endif
  input  logic            jalr_en,
  input  logic            jal_en,
  input  logic            auipc_en,
  input  logic            lui_en,
  output logic [XLEN-1:0] result_out
);

  import alu_pkg::*;

  alu_op_t         op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] shf;
  logic [XLEN-1:0] result_d;
  logic [XLEN-1:0] result_q;
  logic            sltu_bit;

`ifdef ALU_SLTU_EN
  assign sltu_bit = sltu_en;
`else
  assign sltu_bit = 1'b0;
`endif

  // gather the strobes into the one-hot op vector
  always_comb begin
    op            = '0;
    op[OP_ADD]    = add_en;
    op[OP_SUB]    = sub_en;
    op[OP_AND]    = and_en;
    op[OP_OR]     = or_en;
    op[OP_XOR]    = xor_en;
    op[OP_SLL]    = sll_en;
    op[OP_SRL]    = srl_en;
    op[OP_SRA]    = sra_en;
    op[OP_SLT]    = slt_en;
    op[OP_JALR]   = jalr_en;
    op[OP_JAL]    = jal_en;
    op[OP_AUIPC]  = auipc_en;
    op[OP_LUI]    = lui_en;
    op[OP_SLTU]   = sltu_bit;
  end

  assign opa = src1_data;
  assign opb = imm_sel ? imm_val : src2_data;

  alu_shifter u_shf (
    .a_i     (opa),
    .shamt_i (opb[SHAMT_W-1:0]),
    .mode_i  ({op[OP_SLL], op[OP_SRL], op[OP_SRA]}),
    .y_o     (shf)
  );

  // fixed-priority result select; several strobes may be set at once
  always_comb begin
    result_d = '0;
    priority case (1'b1)
      op[OP_LUI]:   result_d = imm_val;
      op[OP_AUIPC]: result_d = pc_in + imm_val;
      op[OP_JAL]:   result_d = pc_in + PC_STEP;
      op[OP_JALR]:  result_d = pc_in + PC_STEP;
      op[OP_ADD]:   result_d = opa + opb;
      op[OP_SUB]:   result_d = opa - opb;
      op[OP_AND]:   result_d = opa & opb;
      op[OP_OR]:    result_d = opa | opb;
      op[OP_XOR]:   result_d = opa ^ opb;
      op[OP_SLL]:   result_d = shf;
      op[OP_SRL]:   result_d = shf;
      op[OP_SRA]:   result_d = shf;
      op[OP_SLT]:
        result_d = {{(XLEN-1){1'b0}},
                    $signed(opa) < $signed(opb)};
      op[OP_SLTU]:
        result_d = {{(XLEN-1){1'b0}}, opa < opb};
      default:      result_d = '0;
    endcase
  end

  // capture the result; synchronous reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) result_q <= '0;
    else        result_q <= result_d;
  end

  assign result_out = result_q;

endmodule

// File: tb/tb_rv32_alu.sv
// Directed scoreboard bench for rv32_alu.
// Build with +define+ALU_SLTU_EN to exercise sltu as well.
module tb_rv32_alu;

  localparam int E_ADD   = 0;
  localparam int E_SUB   = 1;
  localparam int E_AND   = 2;
  localparam int E_OR    = 3;
  localparam int E_XOR   = 4;
  localparam int E_SLL   = 5;
  localparam int E_SRL   = 6;
  localparam int E_SRA   = 7;
  localparam int E_SLT   = 8;
  localparam int E_JALR  = 9;
  localparam int E_JAL   = 10;
  localparam int E_AUIPC = 11;
  localparam int E_LUI   = 12;
  localparam int E_SLTU  = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [31:0] imm = '0;
  logic        isel = 1'b0;
  logic [13:0] en = '0;
  logic [31:0] result_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  rv32_alu #(.XLEN(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_in      (pc_in),
    .src1_data  (src1),
    .src2_data  (src2),
    .imm_val    (imm),
    .imm_sel    (isel),
    .add_en     (en[E_ADD]),
    .sub_en     (en[E_SUB]),
    .and_en     (en[E_AND]),
    .or_en      (en[E_OR]),
    .xor_en     (en[E_XOR]),
    .sll_en     (en[E_SLL]),
    .srl_en     (en[E_SRL]),
    .sra_en     (en[E_SRA]),
    .slt_en     (en[E_SLT]),
`ifdef ALU_SLTU_EN
    .sltu_en    (en[E_SLTU]),
`endif
    .jalr_en    (en[E_JALR]),
    .jal_en     (en[E_JAL]),
    .auipc_en   (en[E_AUIPC]),
    .lui_en     (en[E_LUI]),
    .result_out (result_out)
  );

  function automatic logic [13:0] b(input int i);
    logic [13:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive(input string tag, input logic [13:0] e,
                       input logic [31:0] a, input logic [31:0] bb,
                       input logic [31:0] im, input logic s,
                       input logic [31:0] pc, input logic [31:0] exp);
    @(negedge clk);
    en = e; src1 = a; src2 = bb; imm = im; isel = s; pc_in = pc;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic check_one();
    logic [31:0] want;
    string       t;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty got=%h exp=none", result_out);
    end else begin
      want = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert (result_out === want) else begin
        errors++;
        $error("FAIL %s got=%h exp=%h", t, result_out, want);
      end
    end
  endtask

  task automatic step(input string tag, input logic [13:0] e,
                      input logic [31:0] a, input logic [31:0] bb,
                      input logic [31:0] im, input logic s,
                      input logic [31:0] pc, input logic [31:0] exp);
    drive(tag, e, a, bb, im, s, pc, exp);
    check_one();
  endtask

  initial begin
    rst_n = 1'b0;
    step("rst_hold0", b(E_ADD), 5, 7, 0, 0, 0, 32'h0);
    step("rst_hold1", b(E_ADD), 5, 7, 0, 0, 0, 32'h0);
    rst_n = 1'b1;
    step("rst_first", b(E_ADD), 5, 7, 0, 0, 0, 32'h0000000C);

    step("add_reg", b(E_ADD), 32'h10, 32'h20, 32'h0, 0, 0, 32'h30);
    step("add_imm", b(E_ADD), 32'h10, 32'h20, 32'hFFFFFFFF, 1, 0,
         32'h0000000F);
    step("sub_neg", b(E_SUB), 32'h0, 32'h1, 32'h0, 0, 0, 32'hFFFFFFFF);
    step("sub_imm", b(E_SUB), 32'h100, 32'h0, 32'h1, 1, 0, 32'hFF);

    step("and", b(E_AND), 32'hF0F0F0F0, 32'h0F0F00FF, 0, 0, 0,
         32'h000000F0);
    step("or_imm", b(E_OR), 32'hF0F0F0F0, 0, 32'h0F0F00FF, 1, 0,
         32'hFFFFF0FF);
    step("xor", b(E_XOR), 32'hF0F0F0F0, 32'h0F0F00FF, 0, 0, 0,
         32'hFFFFF00F);

    step("sll", b(E_SLL), 32'h80000000, 32'h24, 0, 0, 0, 32'h0);
    step("srl", b(E_SRL), 32'h80000000, 32'h24, 0, 0, 0, 32'h08000000);
    step("sra", b(E_SRA), 32'h80000000, 32'h24, 0, 0, 0, 32'hF8000000);
    step("sra31", b(E_SRA), 32'h80000000, 0, 32'h1F, 1, 0, 32'hFFFFFFFF);
    step("sll_lo", b(E_SLL), 32'h00000003, 32'hFFFFFFE1, 0, 0, 0,
         32'h00000006);

    step("slt_m1_1", b(E_SLT), 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h1);
    step("slt_1_m1", b(E_SLT), 32'h1, 32'hFFFFFFFF, 0, 0, 0, 32'h0);
    step("slt_eq", b(E_SLT), 32'h1234, 32'h1234, 0, 0, 0, 32'h0);
    step("slt_min", b(E_SLT), 32'h80000000, 32'h7FFFFFFF, 0, 0, 0, 32'h1);
`ifdef ALU_SLTU_EN
    step("sltu_m1_1", b(E_SLTU), 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0);
    step("sltu_1_m1", b(E_SLTU), 32'h1, 32'hFFFFFFFF, 0, 0, 0, 32'h1);
    step("slt_over_sltu", b(E_SLT) | b(E_SLTU), 32'h1, 32'hFFFFFFFF,
         0, 0, 0, 32'h0);
`endif

    step("jal", b(E_JAL), 0, 0, 32'h12345000, 0, 32'h1000, 32'h1004);
    step("jalr", b(E_JALR), 32'h55, 0, 32'h12345000, 1, 32'h1000,
         32'h1004);
    step("auipc", b(E_AUIPC), 0, 32'h999, 32'h12345000, 0, 32'h1000,
         32'h12346000);
    step("lui", b(E_LUI), 32'h7, 32'h999, 32'h12345000, 0, 32'h1000,
         32'h12345000);
    step("jal_wrap", b(E_JAL), 0, 0, 0, 0, 32'hFFFFFFFC, 32'h0);

    step("idle", 14'h0, 32'h5, 32'h7, 32'h9, 0, 32'h1000, 32'h0);
    step("lui_over_add", b(E_LUI) | b(E_ADD), 32'h5, 32'h7,
         32'h12345000, 0, 0, 32'h12345000);
    step("jal_over_sub", b(E_JAL) | b(E_SUB), 32'h5, 32'h7, 0, 0,
         32'h2000, 32'h2004);
    step("add_over_slt", b(E_ADD) | b(E_SLT), 32'h5, 32'h7, 0, 0, 0,
         32'hC);
    step("auipc_over_jal", b(E_AUIPC) | b(E_JAL), 0, 0, 32'h10, 0,
         32'h100, 32'h110);

    step("b2b_add", b(E_ADD), 32'd1, 32'd2, 0, 0, 0, 32'd3);
    step("b2b_sub", b(E_SUB), 32'd10, 32'd4, 0, 0, 0, 32'd6);
    step("b2b_xor", b(E_XOR), 32'hFF, 32'h0F, 0, 0, 0, 32'hF0);
    step("b2b_idle", 14'h0, 32'hFF, 32'h0F, 0, 0, 0, 32'h0);

    rst_n = 1'b0;
    step("rst_mid", b(E_ADD), 32'd1, 32'd1, 0, 0, 0, 32'h0);
    rst_n = 1'b1;
    step("post_rst", b(E_OR), 32'hA0, 32'h0A, 0, 0, 0, 32'hAA);

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain got=%0d exp=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
